// File: rtl/operand_matrix_streamer.sv
// Streams an N x N operand matrix from registered-read storage as a valid/ready element stream.
// First beat 2 cycles after the start edge; a 4-entry FIFO absorbs ready_i stalls and throttles read issue.

// Small synchronous FIFO with occupancy count; DEPTH must be a power of two.
module oms_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
endmodule

module operand_matrix_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DIM_WIDTH  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DIM_WIDTH-1:0]  dim_i,
  input  logic                  transpose_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int FIFO_DEPTH = 4;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state;
  logic [DIM_WIDTH-1:0]  dim_q;
  logic                  transpose_q;
  logic [DIM_WIDTH-1:0]  r;
  logic [DIM_WIDTH-1:0]  c;
  logic                  pend;
  logic                  pend_last;
  logic                  busy_q;
  logic                  done_q;
  logic [CW-1:0]         occ;
  logic [DATA_WIDTH:0]   head;
  logic [DIM_WIDTH-1:0]  dim_clamped;
  logic [3:0]            room;
  logic                  issue;
  logic                  last_rc;
  logic                  pop;

  assign dim_clamped = (dim_i > DIM_WIDTH'(MAX_DIM)) ? DIM_WIDTH'(MAX_DIM) : dim_i;
  // Reserve a slot for the read already in flight so the FIFO can never overflow.
  assign room    = 4'(occ) + 4'(pend);
  assign issue   = (state == ISSUE) && (room < 4'(FIFO_DEPTH));
  assign last_rc = (r == dim_q - DIM_WIDTH'(1)) && (c == dim_q - DIM_WIDTH'(1));
  assign valid_o = (occ != '0);
  assign pop     = valid_o && ready_i;

  oms_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (pend),
    .push_data ({pend_last, mem_rdata_i}),
    .pop       (pop),
    .head      (head),
    .count     (occ)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      dim_q       <= '0;
      transpose_q <= 1'b0;
      r           <= '0;
      c           <= '0;
      pend        <= 1'b0;
      pend_last   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pend      <= issue;
      pend_last <= issue && last_rc;
      done_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            dim_q       <= dim_clamped;
            transpose_q <= transpose_i;
            r           <= '0;
            c           <= '0;
            if (dim_clamped == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= ISSUE;
              busy_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Counters stop on the final read so the address holds through DRAIN.
          if (issue) begin
            if (last_rc) begin
              state <= DRAIN;
            end else if (!transpose_q) begin
              if (c == dim_q - DIM_WIDTH'(1)) begin
                c <= '0;
                r <= r + DIM_WIDTH'(1);
              end else begin
                c <= c + DIM_WIDTH'(1);
              end
            end else begin
              if (r == dim_q - DIM_WIDTH'(1)) begin
                r <= '0;
                c <= c + DIM_WIDTH'(1);
              end else begin
                r <= r + DIM_WIDTH'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (pop && head[DATA_WIDTH]) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          r     <= '0;
          c     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr_o = ADDR_WIDTH'(r) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(c);
  assign data_o     = valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign last_o     = valid_o && head[DATA_WIDTH];
  assign busy_o     = busy_q;
  assign done_o     = done_q;
endmodule

// File: tb/tb_operand_matrix_streamer.sv
// Scoreboard bench for operand_matrix_streamer with a registered-read storage model.
module tb_operand_matrix_streamer;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  dim_i = '0;
  logic        transpose_i = 1'b0;
  logic [3:0]  mem_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        last_o;
  logic        busy_o;
  logic        done_o;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] storage [16];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_hs_cyc = 0;
  int          done_cyc = 0;
  int          done_cnt = 0;
  int          beats_seen = 0;
  bit          first_pending = 1'b0;
  bit          lat_check = 1'b0;
  bit          stalled_prev = 1'b0;
  logic [31:0] prev_data = '0;

  operand_matrix_streamer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .dim_i       (dim_i),
    .transpose_i (transpose_i),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc = cyc + 1;
    mem_rdata_i <= storage[mem_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake.
  always @(negedge clk_i) begin
    if (valid_o) begin
      if (first_pending) begin
        first_pending = 1'b0;
        if (lat_check) check("first_beat_latency", 32'(cyc - start_cyc), 32'd2);
      end
      if (stalled_prev) check("stall_stable", data_o, prev_data);
      if (ready_i) begin
        check("beat_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("beat_data", data_o, e.data);
          check("beat_last", 32'(last_o), 32'(e.last));
        end
        beats_seen++;
        if (last_o) last_hs_cyc = cyc;
      end
      stalled_prev = !ready_i;
      prev_data    = data_o;
    end else begin
      stalled_prev = 1'b0;
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic int clamp_dim(input int d);
    return (d > 4) ? 4 : d;
  endfunction

  task automatic push_expected(input int dim, input bit tr);
    int n;
    n = clamp_dim(dim);
    for (int o = 0; o < n; o++) begin
      for (int i = 0; i < n; i++) begin
        exp_t e;
        int   addr;
        addr   = tr ? (i * 4 + o) : (o * 4 + i);
        e.data = storage[addr];
        e.last = (o == n - 1) && (i == n - 1);
        sb.push_back(e);
      end
    end
  endtask

  // mode 0: ready held high; 1: ready toggling plus a 5-cycle low burst; 2: start re-pulsed while busy
  task automatic run(input int dim, input bit tr, input int mode, input bit chk_lat);
    push_expected(dim, tr);
    done_cnt      = 0;
    beats_seen    = 0;
    first_pending = 1'b1;
    lat_check     = chk_lat;
    ready_i       = 1'b1;
    dim_i         = 3'(dim);
    transpose_i   = tr;
    start_i       = 1'b1;
    @(posedge clk_i);
    #1;
    start_i   = 1'b0;
    start_cyc = cyc;
    check("busy_after_start", 32'(busy_o), 32'(clamp_dim(dim) > 0));
    for (int n = 0; n < 300; n++) begin
      if (done_cnt > 0) break;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      if (mode == 1) ready_i = (n >= 10 && n < 15) ? 1'b0 : 1'(n % 2);
      if (mode == 2 && n == 4) begin
        start_i     = 1'b1;
        dim_i       = 3'd2;
        transpose_i = ~tr;
      end
    end
    check("done_seen", 32'(done_cnt), 32'd1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    if (clamp_dim(dim) > 0) check("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
    else                    check("done_dim0_latency", 32'(done_cyc), 32'(start_cyc));
    repeat (3) @(posedge clk_i);
    #1;
    check("done_single_pulse", 32'(done_cnt), 32'd1);
    check("busy_idle", 32'(busy_o), 32'd0);
    check("addr_idle", 32'(mem_addr_o), 32'd0);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) storage[i] = 32'(i);
    #12;
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    run(4, 1'b0, 0, 1'b1);   // row-major, full rate
    run(4, 1'b1, 0, 1'b1);   // column-major
    run(2, 1'b0, 0, 1'b1);   // stride MAX_DIM
    run(4, 1'b0, 1, 1'b0);   // back-pressure
    run(0, 1'b0, 0, 1'b0);   // empty matrix
    run(7, 1'b1, 0, 1'b1);   // clamped dimension
    run(3, 1'b0, 2, 1'b1);   // start while busy ignored

    // Abort mid-stream with reset after beat 6.
    push_expected(4, 1'b0);
    beats_seen    = 0;
    first_pending = 1'b1;
    lat_check     = 1'b0;
    ready_i       = 1'b1;
    dim_i         = 3'd4;
    transpose_i   = 1'b0;
    start_i       = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (beats_seen >= 6) break;
      @(posedge clk_i);
      #1;
    end
    check("reached_beat6", 32'(beats_seen >= 6), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    sb.delete();
    done_cnt = 0;
    check("abort_valid", 32'(valid_o), 32'd0);
    check("abort_data", data_o, 32'd0);
    check("abort_last", 32'(last_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_addr", 32'(mem_addr_o), 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_no_beats", 32'(valid_o), 32'd0);
    run(4, 1'b0, 0, 1'b1);   // fresh stream after abort

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
